// File: rtl/mul_sign_ctrl_if.sv
// mul_sign_ctrl_if
// Bundles the three handshakes around the multiply sign controller:
//   issue_*  reservation station -> controller (valid/ready, op, operands, tag)
//   flush    pipeline squash into the controller
//   mul_*    controller <-> unsigned iterative multiplier (valid/ready, yumi)
//   cdb_*    controller -> common data bus (valid/grant, tag, data)
// Modport slave is the controller's view; master is the environment's view.
interface mul_sign_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [TAG_W-1:0] issue_tag;
  logic             flush;
  logic             mul_valid_in;
  logic             mul_ready;
  logic [31:0]      mul_multiplier;
  logic [31:0]      mul_multiplicand;
  logic             mul_valid_out;
  logic [63:0]      mul_product;
  logic             mul_yumi;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_grant;

  modport slave (
    input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_tag, flush,
           mul_ready, mul_valid_out, mul_product, cdb_grant,
    output issue_ready, mul_valid_in, mul_multiplier, mul_multiplicand,
           mul_yumi, cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output issue_valid, issue_op, issue_rs1, issue_rs2, issue_tag, flush,
           mul_ready, mul_valid_out, mul_product, cdb_grant,
    input  issue_ready, mul_valid_in, mul_multiplier, mul_multiplicand,
           mul_yumi, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/mul_sign_ctrl.sv
// mul_sign_ctrl
// Sequences one RV32M multiply (MUL/MULH/MULHSU/MULHU) at a time through an
// unsigned shift-add multiplier: operands are turned into magnitudes, the
// 64-bit product is sign-corrected, and the low or high word is held for the
// CDB together with its tag.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   bus    mul_sign_ctrl_if.slave (issue, flush, multiplier and CDB signals)
//
// state | meaning
// IDLE  | ready for a new op
// SEND  | presenting magnitudes to the multiplier, waiting for its ready
// WAIT  | multiplier busy, waiting for the product
// HOLD  | result on the CDB until granted
// DRAIN | op was squashed; consume and discard the product still in flight
module mul_sign_ctrl #(
  parameter int TAG_W       = 6,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mul_sign_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, HOLD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [31:0]      mplier_q, mcand_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  logic        s1, s2, neg_in, zero_in, accept, load_result;
  logic [31:0] mag1, mag2, result;
  logic [63:0] prod_fix;

  always_comb begin
    s1       = (bus.issue_op != 2'b11);
    s2       = (bus.issue_op[1] == 1'b0);
    neg_in   = (s1 & bus.issue_rs1[31]) ^ (s2 & bus.issue_rs2[31]);
    mag1     = (s1 & bus.issue_rs1[31]) ? (32'd0 - bus.issue_rs1) : bus.issue_rs1;
    mag2     = (s2 & bus.issue_rs2[31]) ? (32'd0 - bus.issue_rs2) : bus.issue_rs2;
    zero_in  = (bus.issue_rs1 == 32'd0) || (bus.issue_rs2 == 32'd0);
    prod_fix = neg_q ? (~bus.mul_product + 64'd1) : bus.mul_product;
    result   = (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // Ready is gated by reset and flush so the RS never sees a handshake that
  // the controller ignores.
  assign bus.issue_ready  = reset & ~bus.flush & (state_q == IDLE);
  assign accept           = bus.issue_valid & bus.issue_ready;
  assign bus.mul_valid_in = (state_q == SEND);
  assign bus.mul_yumi     = ((state_q == WAIT) || (state_q == DRAIN)) & bus.mul_valid_out;
  assign bus.cdb_valid    = (state_q == HOLD);
  assign load_result      = (state_q == WAIT) & bus.mul_valid_out & ~bus.flush;

  assign bus.mul_multiplier   = mplier_q;
  assign bus.mul_multiplicand = mcand_q;
  assign bus.cdb_tag          = tag_q;
  assign bus.cdb_data         = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (ZERO_BYPASS && zero_in) ? HOLD : SEND;
      end
      SEND: begin
        // A handshake that lands with the flush still launches the multiplier.
        if (bus.flush)          state_d = bus.mul_ready ? DRAIN : IDLE;
        else if (bus.mul_ready) state_d = WAIT;
      end
      WAIT: begin
        // Product arriving with the flush is consumed now, nothing left to drain.
        if (bus.mul_valid_out)  state_d = bus.flush ? IDLE : HOLD;
        else if (bus.flush)     state_d = DRAIN;
      end
      HOLD: begin
        if (bus.flush || bus.cdb_grant) state_d = IDLE;
      end
      DRAIN: begin
        if (bus.mul_valid_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= 2'b00;
      neg_q    <= 1'b0;
      mplier_q <= 32'd0;
      mcand_q  <= 32'd0;
      tag_q    <= '0;
      data_q   <= 32'd0;
    end else begin
      if (accept) begin
        op_q     <= bus.issue_op;
        neg_q    <= neg_in;
        mplier_q <= mag1;
        mcand_q  <= mag2;
        tag_q    <= bus.issue_tag;
        if (ZERO_BYPASS && zero_in) data_q <= 32'd0;
      end
      if (load_result) data_q <= result;
    end
  end

endmodule

// File: tb/tb_mul_sign_ctrl.sv
module tb_mul_sign_ctrl;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_sign_ctrl_if #(.TAG_W(TAG_W)) bus();

  mul_sign_ctrl #(.TAG_W(TAG_W), .ZERO_BYPASS(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: sign- or zero-extend each operand to 64 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11 && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    eb = (op[1] == 1'b0 && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural unsigned multiplier with random latency and ready stalls.
  logic        busy, mvo, rdy_rand = 1'b1;
  logic [63:0] prod;
  int          cnt;
  int          lat_force = -1;
  bit          stall_en  = 1'b1;

  assign bus.mul_ready     = !busy && rdy_rand;
  assign bus.mul_valid_out = mvo;
  assign bus.mul_product   = prod;

  always @(posedge clk) rdy_rand <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0; mvo <= 1'b0; cnt <= 0; prod <= 64'd0;
    end else if (!busy) begin
      if (bus.mul_valid_in && bus.mul_ready) begin
        busy <= 1'b1;
        prod <= {32'd0, bus.mul_multiplier} * {32'd0, bus.mul_multiplicand};
        cnt  <= (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
      end
    end else if (!mvo) begin
      if (cnt == 0) mvo <= 1'b1;
      else          cnt <= cnt - 1;
    end else if (bus.mul_yumi) begin
      mvo <= 1'b0; busy <= 1'b0;
    end
  end

  // CDB grant driver: 0 = held low, 1 = held high, 2 = random.
  int grant_mode = 1;
  always @(posedge clk) begin
    #1;
    bus.cdb_grant = (grant_mode == 2) ? ($urandom_range(0, 1) == 1) : (grant_mode == 1);
  end

  // Monitor / scoreboard.
  int yumi_cnt = 0;
  int mvi_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.mul_yumi) begin
        check("yumi_without_valid", {63'd0, bus.mul_valid_out}, 64'd1);
        yumi_cnt++;
      end
      if (bus.mul_valid_in) mvi_cnt++;
      if (bus.cdb_valid && bus.cdb_grant && !bus.flush) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_cdb: tag %0d data %h, no result pending", bus.cdb_tag, bus.cdb_data);
        end else begin
          e = exp_q.pop_front();
          check("cdb_tag", {58'd0, bus.cdb_tag}, {58'd0, e.tag});
          check("cdb_data", {32'd0, bus.cdb_data}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input bit push, input logic [31:0] exp_data);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.issue_valid = 1'b1; bus.issue_op = op;
    bus.issue_rs1 = a; bus.issue_rs2 = b; bus.issue_tag = tag;
    @(negedge clk);
    while (!bus.issue_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL issue_timeout: issue_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    if (push && n < 200) begin
      e.tag = tag; e.data = exp_data;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain_q();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_mul_handshake();
    int n = 0;
    @(negedge clk);
    while (!(bus.mul_valid_in && bus.mul_ready) && n < 100) begin n++; @(negedge clk); end
    check("mul_handshake_seen", {63'd0, bus.mul_valid_in && bus.mul_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      a, b, d0;
    logic [TAG_W-1:0] t0;
    logic [1:0]       op;
    logic [TAG_W-1:0] tg;
    int               m0, y0, n;
    bit               stable;

    bus.issue_valid = 1'b0; bus.issue_op = 2'b00; bus.issue_rs1 = 32'd0;
    bus.issue_rs2 = 32'd0; bus.issue_tag = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cdb_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("rst_mul_valid_in", {63'd0, bus.mul_valid_in}, 64'd0);
    check("rst_mul_yumi", {63'd0, bus.mul_yumi}, 64'd0);
    check("rst_cdb_tag", {58'd0, bus.cdb_tag}, 64'd0);
    check("rst_cdb_data", {32'd0, bus.cdb_data}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, bus.issue_ready}, 64'd1);

    grant_mode = 1;
    issue(2'b00, 32'd7, 32'd6, 6'd3, 1'b1, 32'h0000002A);
    issue(2'b01, 32'hFFFFFFF9, 32'd6, 6'd4, 1'b1, 32'hFFFFFFFF);
    issue(2'b01, 32'h80000000, 32'h80000000, 6'd5, 1'b1, 32'h40000000);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd6, 1'b1, 32'hFFFFFFFE);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd7, 1'b1, 32'hFFFFFFFF);
    drain_q();

    // Zero bypass: result next cycle, multiplier never requested.
    grant_mode = 0;
    m0 = mvi_cnt;
    issue(2'b00, 32'd0, 32'd12345, 6'd5, 1'b1, 32'd0);
    @(negedge clk);
    check("bypass_cdb_valid", {63'd0, bus.cdb_valid}, 64'd1);
    check("bypass_cdb_data", {32'd0, bus.cdb_data}, 64'd0);
    repeat (3) @(negedge clk);
    check("bypass_no_mul_req", 64'(mvi_cnt - m0), 64'd0);
    grant_mode = 1;
    drain_q();

    // HOLD with grant withheld for 10 cycles.
    grant_mode = 0;
    issue(2'b00, 32'd7, 32'd6, 6'd3, 1'b1, 32'd42);
    n = 0;
    @(negedge clk);
    while (!bus.cdb_valid && n < 100) begin n++; @(negedge clk); end
    check("hold_reached", {63'd0, bus.cdb_valid}, 64'd1);
    d0 = bus.cdb_data; t0 = bus.cdb_tag;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.cdb_valid || bus.issue_ready || bus.cdb_data !== d0 || bus.cdb_tag !== t0)
        stable = 1'b0;
    end
    check("hold_stable", {63'd0, stable}, 64'd1);
    grant_mode = 1;
    drain_q();
    @(negedge clk);
    check("cdb_valid_drop_after_grant", {63'd0, bus.cdb_valid}, 64'd0);

    // Flush during WAIT, then a fresh MUL.
    stall_en = 1'b0; lat_force = 8;
    y0 = yumi_cnt;
    issue(2'b00, 32'd3, 32'd5, 6'd9, 1'b0, 32'd0);
    wait_mul_handshake();
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    issue(2'b00, 32'd7, 32'd6, 6'd3, 1'b1, 32'd42);
    drain_q();
    repeat (2) @(negedge clk);
    check("flush_two_products_consumed", 64'(yumi_cnt - y0), 64'd2);

    // Reset asserted while WAIT.
    issue(2'b00, 32'd7, 32'd6, 6'd1, 1'b0, 32'd0);
    wait_mul_handshake();
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("rstw_mul_valid_in", {63'd0, bus.mul_valid_in}, 64'd0);
    check("rstw_mul_yumi", {63'd0, bus.mul_yumi}, 64'd0);
    check("rstw_cdb_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("rstw_cdb_data", {32'd0, bus.cdb_data}, 64'd0);
    check("rstw_cdb_tag", {58'd0, bus.cdb_tag}, 64'd0);
    check("rstw_issue_ready", {63'd0, bus.issue_ready}, 64'd0);
    check("rstw_multiplier", {32'd0, bus.mul_multiplier}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rstw_ready_after", {63'd0, bus.issue_ready}, 64'd1);
    lat_force = -1; stall_en = 1'b1;

    // Randomized ops against the reference model.
    grant_mode = 2;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      op = 2'($urandom_range(0, 3));
      tg = TAG_W'($urandom_range(0, 63));
      issue(op, a, b, tg, 1'b1, ref_mul(op, a, b));
    end
    drain_q();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
